// File: rtl/vlt_pkg.sv
// Shared definitions for the vlt_* vulnerability accumulators: store opcodes and
// the per-opcode/importance shift-weight table.
package vlt_pkg;

  localparam int unsigned SB    = 6;
  localparam int unsigned SH    = 7;
  localparam int unsigned SW    = 8;
  localparam int unsigned SD    = 10;
  localparam int unsigned SWL   = 15;
  localparam int unsigned SWR   = 16;
  localparam int unsigned SDL   = 17;
  localparam int unsigned SDR   = 18;
  localparam int unsigned SC_0  = 21;
  localparam int unsigned SCD_0 = 23;

  // en=0 marks opcodes that carry no vulnerable bits.
  typedef struct packed {
    logic       en;
    logic [2:0] s1;
    logic [2:0] s2;
  } shift_pair_t;

  function automatic shift_pair_t lookup_shift(input logic [31:0] opcode,
                                               input logic        important);
    shift_pair_t sp;
    sp = '{en: 1'b0, s1: 3'd0, s2: 3'd0};
    case (opcode)
      SW, SH, SWL, SWR:            sp = '{en: 1'b1, s1: 3'd6, s2: important ? 3'd5 : 3'd3};
      SB:                          sp = '{en: 1'b1, s1: 3'd6, s2: important ? 3'd4 : 3'd3};
      SD, SDL, SDR, SC_0, SCD_0:   sp = '{en: 1'b1, s1: important ? 3'd7 : 3'd6, s2: 3'd3};
      default:                     sp = '{en: 1'b0, s1: 3'd0, s2: 3'd0};
    endcase
    return sp;
  endfunction

endpackage

// File: rtl/vlt_sq_entry.sv
// One store-queue entry shadow: valid bit, saturating residency age, captured
// opcode and importance flag.
module vlt_sq_entry #(
  parameter int unsigned OPC_W = 9,
  parameter int unsigned AGE_W = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             alloc_i,
  input  logic             dealloc_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             important_i,
  output logic             valid_o,
  output logic [AGE_W-1:0] age_o,
  output logic [OPC_W-1:0] opcode_o,
  output logic             important_o
);

  logic             valid_q;
  logic [AGE_W-1:0] age_q;
  logic [OPC_W-1:0] opcode_q;
  logic             important_q;

  // Alloc takes priority so a same-cycle retire/reinstall leaves the new occupant.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q     <= 1'b0;
      age_q       <= '0;
      opcode_q    <= '0;
      important_q <= 1'b0;
    end else if (alloc_i) begin
      valid_q     <= 1'b1;
      age_q       <= AGE_W'(1);
      opcode_q    <= opcode_i;
      important_q <= important_i;
    end else if (dealloc_i) begin
      valid_q <= 1'b0;
      age_q   <= '0;
    end else if (valid_q && (age_q != '1)) begin
      age_q <= age_q + AGE_W'(1);
    end
  end

  assign valid_o     = valid_q;
  assign age_o       = age_q;
  assign opcode_o    = opcode_q;
  assign important_o = important_q;

endmodule

// File: rtl/vlt_sq_accum.sv
// Store-queue vulnerability accumulator: weights each retired entry's residency by
// its opcode/importance and sums into a saturating accumulator (two-stage pipe).
module vlt_sq_accum
  import vlt_pkg::*;
#(
  parameter  int unsigned ENTRIES = 16,
  parameter  int unsigned NPORTS  = 2,
  parameter  int unsigned OPC_W   = 9,
  parameter  int unsigned AGE_W   = 10,
  parameter  int unsigned ACC_W   = 40,
  localparam int unsigned IDX_W   = $clog2(ENTRIES),
  localparam int unsigned CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    alloc_v_i,
  input  logic [IDX_W-1:0]        alloc_idx_i,
  input  logic [OPC_W-1:0]        alloc_opcode_i,
  input  logic                    alloc_important_i,
  input  logic [NPORTS-1:0]       dealloc_v_i,
  input  logic [NPORTS*IDX_W-1:0] dealloc_idx_i,
  input  logic                    clear_i,
  output logic [ACC_W-1:0]        acc_o,
  output logic [CNT_W-1:0]        live_o,
  output logic                    sat_o,
  output logic                    err_o
);

  localparam int unsigned CW  = AGE_W + 8;
  localparam int unsigned AW1 = ACC_W + 1;

  logic [ENTRIES-1:0] ent_valid;
  logic [ENTRIES-1:0] ent_alloc;
  logic [ENTRIES-1:0] ent_dealloc;
  logic [ENTRIES-1:0] ent_imp;
  logic [AGE_W-1:0]   ent_age [ENTRIES];
  logic [OPC_W-1:0]   ent_opc [ENTRIES];

  logic [IDX_W-1:0]   port_idx     [NPORTS];
  logic [CW-1:0]      port_contrib [NPORTS];
  logic [NPORTS-1:0]  port_take;
  logic               dup;
  shift_pair_t        sp;
  logic               err_now;

  logic [NPORTS-1:0]  s1_v_q;
  logic [CW-1:0]      s1_contrib_q [NPORTS];
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic               err_q, err_d;
  logic [AW1-1:0]     acc_sum;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
    vlt_sq_entry #(
      .OPC_W (OPC_W),
      .AGE_W (AGE_W)
    ) u_entry (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .alloc_i     (ent_alloc[e]),
      .dealloc_i   (ent_dealloc[e]),
      .opcode_i    (alloc_opcode_i),
      .important_i (alloc_important_i),
      .valid_o     (ent_valid[e]),
      .age_o       (ent_age[e]),
      .opcode_o    (ent_opc[e]),
      .important_o (ent_imp[e])
    );
  end

  // Lower-numbered ports win on index collisions; the loser only flags an error.
  always_comb begin
    ent_dealloc = '0;
    ent_alloc   = '0;
    port_take   = '0;
    err_now     = 1'b0;
    dup         = 1'b0;
    sp          = '0;
    for (int p = 0; p < NPORTS; p++) begin
      port_idx[p]     = dealloc_idx_i[p*IDX_W +: IDX_W];
      port_contrib[p] = '0;
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (dealloc_v_i[p]) begin
        dup = 1'b0;
        for (int q = 0; q < p; q++) begin
          if (dealloc_v_i[q] && (port_idx[q] == port_idx[p])) dup = 1'b1;
        end
        if (dup || !ent_valid[port_idx[p]]) begin
          err_now = 1'b1;
        end else begin
          port_take[p]             = 1'b1;
          ent_dealloc[port_idx[p]] = 1'b1;
          sp = lookup_shift(32'(ent_opc[port_idx[p]]), ent_imp[port_idx[p]]);
          if (sp.en) begin
            port_contrib[p] = (CW'(ent_age[port_idx[p]]) << sp.s1) +
                              (CW'(ent_age[port_idx[p]]) << sp.s2);
          end
        end
      end
    end
    if (alloc_v_i) begin
      ent_alloc[alloc_idx_i] = 1'b1;
      if (ent_valid[alloc_idx_i] && !ent_dealloc[alloc_idx_i]) err_now = 1'b1;
    end
  end

  // Clear discards the old total but still absorbs this cycle's stage-2 input.
  always_comb begin
    acc_sum = clear_i ? '0 : {1'b0, acc_q};
    for (int p = 0; p < NPORTS; p++) begin
      if (s1_v_q[p]) acc_sum = acc_sum + AW1'(s1_contrib_q[p]);
    end
    acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    sat_d = (clear_i ? 1'b0 : sat_q) | acc_sum[ACC_W];
    err_d = (clear_i ? 1'b0 : err_q) | err_now;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q <= '0;
      for (int p = 0; p < NPORTS; p++) s1_contrib_q[p] <= '0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      s1_v_q <= port_take;
      for (int p = 0; p < NPORTS; p++) s1_contrib_q[p] <= port_contrib[p];
      acc_q  <= acc_d;
      sat_q  <= sat_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    live_o = '0;
    for (int e = 0; e < ENTRIES; e++) live_o = live_o + CNT_W'(ent_valid[e]);
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_vlt_sq_accum.sv
// Directed and random checks of vlt_sq_accum against a cycle-count reference model.
module tb_vlt_sq_accum;

  localparam int unsigned ACC_W   = 20;
  localparam longint      ACC_MAX = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_v;
  logic [3:0]       a_idx;
  logic [8:0]       a_opc;
  logic             a_imp;
  logic [1:0]       d_v;
  logic [3:0]       d_idx0, d_idx1;
  logic             clr;
  logic [ACC_W-1:0] acc_o;
  logic [4:0]       live_o;
  logic             sat_o, err_o;

  int tests = 0;
  int fails = 0;

  bit     m_valid [16];
  int     m_acyc  [16];
  int     m_opc   [16];
  bit     m_imp   [16];
  int     cyc = 0;
  longint m_acc, pend;
  bit     m_sat, m_err;

  int opl [12] = '{6, 7, 8, 10, 15, 16, 17, 18, 21, 23, 99, 0};

  vlt_sq_accum #(.ACC_W(ACC_W)) dut (
    .clk_i             (clk),
    .reset_i           (rst),
    .alloc_v_i         (a_v),
    .alloc_idx_i       (a_idx),
    .alloc_opcode_i    (a_opc),
    .alloc_important_i (a_imp),
    .dealloc_v_i       (d_v),
    .dealloc_idx_i     ({d_idx1, d_idx0}),
    .clear_i           (clr),
    .acc_o             (acc_o),
    .live_o            (live_o),
    .sat_o             (sat_o),
    .err_o             (err_o)
  );

  always #5 clk = ~clk;

  // Bit-cycle weight = 2^s1 + 2^s2 from the opcode/importance table.
  function automatic int weight(int opc, bit imp);
    case (opc)
      7, 8, 15, 16:         return imp ? 96 : 72;
      6:                    return imp ? 80 : 72;
      10, 17, 18, 21, 23:   return imp ? 136 : 72;
      default:              return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_v = 1'b0; a_idx = '0; a_opc = '0; a_imp = 1'b0;
    d_v = '0; d_idx0 = '0; d_idx1 = '0; clr = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_acyc[i] = 0; m_opc[i] = 0; m_imp[i] = 1'b0;
    end
    m_acc = 0; pend = 0; m_sat = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_outputs();
    int live = 0;
    for (int i = 0; i < 16; i++) live += int'(m_valid[i]);
    chk("acc", 64'(acc_o), 64'(m_acc));
    chk("live", 64'(live_o), 64'(live));
    chk("sat", 64'(sat_o), 64'(m_sat));
    chk("err", 64'(err_o), 64'(m_err));
  endtask

  // Present the current inputs for one cycle, advance the model, check outputs.
  task automatic cycle();
    longint c = 0;
    bit     e = 1'b0;
    longint base, s;
    int     idx, dur;
    for (int p = 0; p < 2; p++) begin
      if (d_v[p]) begin
        idx = (p == 0) ? int'(d_idx0) : int'(d_idx1);
        if (p == 1 && d_v[0] && d_idx0 == d_idx1) e = 1'b1;
        else if (!m_valid[idx]) e = 1'b1;
        else begin
          dur = cyc - m_acyc[idx];
          if (dur > 1023) dur = 1023;
          c += longint'(dur) * weight(m_opc[idx], m_imp[idx]);
          m_valid[idx] = 1'b0;
        end
      end
    end
    if (a_v) begin
      idx = int'(a_idx);
      if (m_valid[idx]) e = 1'b1;
      m_valid[idx] = 1'b1; m_acyc[idx] = cyc; m_opc[idx] = int'(a_opc); m_imp[idx] = a_imp;
    end
    @(posedge clk);
    #1;
    base = clr ? 0 : m_acc;
    s = base + pend;
    m_sat = clr ? 1'b0 : m_sat;
    if (s > ACC_MAX) begin
      s = ACC_MAX;
      m_sat = 1'b1;
    end
    m_acc = s;
    m_err = (clr ? 1'b0 : m_err) | e;
    pend = c;
    cyc++;
    check_outputs();
    idle_inputs();
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  task automatic do_alloc(int idx, int opc, bit imp);
    a_v = 1'b1; a_idx = 4'(idx); a_opc = 9'(opc); a_imp = imp;
    cycle();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    cycle();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // SW important held 10 cycles: 960, visible two cycles after dealloc.
    do_clear();
    do_alloc(3, 8, 1'b1);
    idle(9);
    d_v = 2'b01; d_idx0 = 4'd3;
    cycle();
    chk("lat_d1", 64'(acc_o), 64'd0);
    cycle();
    chk("sw_960", 64'(acc_o), 64'd960);

    // SB not important held past the age ceiling: 1023 * 72.
    do_clear();
    do_alloc(7, 6, 1'b0);
    idle(1073);
    d_v = 2'b01; d_idx0 = 4'd7;
    cycle();
    cycle();
    chk("sb_sat_age", 64'(acc_o), 64'd73656);

    // Two ports, two entries: SD important age 4 plus an unweighted opcode.
    do_clear();
    do_alloc(5, 99, 1'b1);
    idle(2);
    do_alloc(2, 10, 1'b1);
    idle(3);
    d_v = 2'b11; d_idx0 = 4'd2; d_idx1 = 4'd5;
    cycle();
    cycle();
    chk("two_port_544", 64'(acc_o), 64'd544);
    chk("two_port_err", 64'(err_o), 64'd0);

    // Same index on both ports, then dealloc of a never-allocated entry.
    do_clear();
    do_alloc(1, 8, 1'b1);
    idle(2);
    d_v = 2'b11; d_idx0 = 4'd1; d_idx1 = 4'd1;
    cycle();
    chk("dup_err", 64'(err_o), 64'd1);
    cycle();
    chk("dup_single", 64'(acc_o), 64'd288);
    do_clear();
    d_v = 2'b01; d_idx0 = 4'd9;
    cycle();
    chk("inv_err", 64'(err_o), 64'd1);
    cycle();
    chk("inv_acc", 64'(acc_o), 64'd0);

    // Same-cycle retire and reinstall of idx 4.
    do_clear();
    do_alloc(4, 7, 1'b1);
    idle(4);
    a_v = 1'b1; a_idx = 4'd4; a_opc = 9'd6; a_imp = 1'b0;
    d_v = 2'b01; d_idx0 = 4'd4;
    cycle();
    chk("swap_err", 64'(err_o), 64'd0);
    cycle();
    chk("swap_old", 64'(acc_o), 64'd480);
    d_v = 2'b01; d_idx0 = 4'd4;
    cycle();
    cycle();
    chk("swap_new", 64'(acc_o), 64'd624);

    // Saturate, then clear coinciding with a contribution of 72.
    do_clear();
    for (int i = 0; i < 16; i++) do_alloc(i, 10, 1'b1);
    idle(1030);
    for (int k = 0; k < 8; k++) begin
      d_v = 2'b11; d_idx0 = 4'(2 * k); d_idx1 = 4'(2 * k + 1);
      cycle();
    end
    idle(2);
    chk("sat_flag", 64'(sat_o), 64'd1);
    chk("sat_acc", 64'(acc_o), 64'(ACC_MAX));
    do_alloc(0, 8, 1'b0);
    d_v = 2'b01; d_idx0 = 4'd0;
    cycle();
    do_clear();
    chk("clr_add_72", 64'(acc_o), 64'd72);
    chk("clr_sat", 64'(sat_o), 64'd0);

    // Reset with a contribution in flight.
    do_alloc(6, 8, 1'b1);
    idle(3);
    d_v = 2'b01; d_idx0 = 4'd6;
    cycle();
    rst = 1'b1;
    #3;
    model_reset();
    check_outputs();
    rst = 1'b0;
    idle(2);
    chk("rst_discard", 64'(acc_o), 64'd0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      a_v    = ($urandom_range(0, 2) != 0);
      a_idx  = 4'($urandom_range(0, 15));
      a_opc  = 9'(opl[$urandom_range(0, 11)]);
      a_imp  = 1'($urandom_range(0, 1));
      d_v    = 2'($urandom_range(0, 3));
      d_idx0 = 4'($urandom_range(0, 15));
      d_idx1 = 4'($urandom_range(0, 15));
      clr    = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
